// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: decodes RV32 B-type branches, resolves direction and
// redirect PC, flags mispredicts, trains a PC-indexed table of saturating
// counters for fetch-stage prediction, and counts resolved/mispredicted
// branches. Results leave through a single registered valid/ready stage.
module branch_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_BITS    = 2,
  parameter int PERF_BITS   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 branch,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      imm,
  input  logic [XLEN-1:0]      rs1_val,
  input  logic [XLEN-1:0]      rs2_val,
  input  logic                 pred_taken,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_is_branch,
  output logic                 out_taken,
  output logic                 out_mispredict,
  output logic [XLEN-1:0]      out_redirect_pc,
  output logic                 out_illegal,
  input  logic [XLEN-1:0]      lookup_pc,
  output logic                 lookup_taken,
  output logic [PERF_BITS-1:0] perf_branches,
  output logic [PERF_BITS-1:0] perf_mispredicts
);

  localparam int IDX = $clog2(BHT_ENTRIES);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  // Weakly not-taken: the value just below the MSB-set half of the range.
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
  localparam logic [PERF_BITS-1:0] PERF_MAX = {PERF_BITS{1'b1}};

  // ---------------------------------------------------------------------------
  // Decode and resolve (combinational, on the incoming request)
  // ---------------------------------------------------------------------------
  logic            op_match;
  logic            funct3_legal;
  logic            cond;
  logic            is_branch;
  logic            illegal;
  logic            taken;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;

  // Decode funct3 into a legality flag and the compare result for that type.
  always_comb begin
    op_match     = (op == OP_BRANCH) && branch;
    funct3_legal = 1'b0;
    cond         = 1'b0;
    case (funct3)
      3'b000: begin funct3_legal = 1'b1; cond = (rs1_val == rs2_val); end
      3'b001: begin funct3_legal = 1'b1; cond = (rs1_val != rs2_val); end
      3'b100: begin funct3_legal = 1'b1; cond = ($signed(rs1_val) <  $signed(rs2_val)); end
      3'b101: begin funct3_legal = 1'b1; cond = ($signed(rs1_val) >= $signed(rs2_val)); end
      3'b110: begin funct3_legal = 1'b1; cond = (rs1_val <  rs2_val); end
      3'b111: begin funct3_legal = 1'b1; cond = (rs1_val >= rs2_val); end
      default: begin funct3_legal = 1'b0; cond = 1'b0; end
    endcase
    is_branch   = op_match && funct3_legal;
    illegal     = op_match && !funct3_legal;
    taken       = is_branch && cond;
    // Anything that is not a taken branch falls through; a taken prediction on
    // a non-branch therefore also redirects to pc+4.
    mispredict  = (taken != pred_taken);
    redirect_pc = taken ? (pc + imm) : (pc + XLEN'(4));
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic out_valid_reg;
  logic accept;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // ---------------------------------------------------------------------------
  // Registered output stage
  // ---------------------------------------------------------------------------
  logic            out_is_branch_reg;
  logic            out_taken_reg;
  logic            out_mispredict_reg;
  logic [XLEN-1:0] out_redirect_pc_reg;
  logic            out_illegal_reg;

  // Load on accept, drop valid on flush or when the consumer drains it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg       <= 1'b0;
      out_is_branch_reg   <= 1'b0;
      out_taken_reg       <= 1'b0;
      out_mispredict_reg  <= 1'b0;
      out_redirect_pc_reg <= '0;
      out_illegal_reg     <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg       <= 1'b1;
      out_is_branch_reg   <= is_branch;
      out_taken_reg       <= taken;
      out_mispredict_reg  <= mispredict;
      out_redirect_pc_reg <= redirect_pc;
      out_illegal_reg     <= illegal;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid       = out_valid_reg;
  assign out_is_branch   = out_is_branch_reg;
  assign out_taken       = out_taken_reg;
  assign out_mispredict  = out_mispredict_reg;
  assign out_redirect_pc = out_redirect_pc_reg;
  assign out_illegal     = out_illegal_reg;

  // ---------------------------------------------------------------------------
  // Branch history table
  // ---------------------------------------------------------------------------
  // Every counter must reset to the same value, so the table is a bank of
  // individually reset registers rather than a RAM.
  logic [CNT_BITS-1:0] bht [BHT_ENTRIES];
  logic [IDX-1:0]      upd_idx;
  logic [IDX-1:0]      look_idx;
  logic [CNT_BITS-1:0] upd_cur;
  logic [CNT_BITS-1:0] upd_next;
  logic                bht_we;
  logic                unused_lookup_bits;

  assign upd_idx  = pc[IDX+1:2];
  assign look_idx = lookup_pc[IDX+1:2];
  assign upd_cur  = bht[upd_idx];
  assign bht_we   = accept && is_branch;
  assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX+2], lookup_pc[1:0]};

  // Saturating step toward the resolved direction.
  always_comb begin
    upd_next = upd_cur;
    if (taken) begin
      if (upd_cur != CNT_MAX) upd_next = upd_cur + 1'b1;
    end else begin
      if (upd_cur != '0) upd_next = upd_cur - 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
      logic [CNT_BITS-1:0] cnt_reg;

      // Each counter trains only when a legal branch at its index is accepted.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg <= CNT_INIT;
        end else if (bht_we && (upd_idx == IDX'(gi))) begin
          cnt_reg <= upd_next;
        end
      end

      assign bht[gi] = cnt_reg;
    end
  endgenerate

  // Lookup reads the registered table, so a same-cycle update is not visible.
  assign lookup_taken = bht[look_idx][CNT_BITS-1];

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic [PERF_BITS-1:0] perf_branches_reg;
  logic [PERF_BITS-1:0] perf_mispredicts_reg;

  // Count accepted legal branches and their mispredicts, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_branches_reg    <= '0;
      perf_mispredicts_reg <= '0;
    end else if (bht_we) begin
      if (perf_branches_reg != PERF_MAX)
        perf_branches_reg <= perf_branches_reg + 1'b1;
      if (mispredict && (perf_mispredicts_reg != PERF_MAX))
        perf_mispredicts_reg <= perf_mispredicts_reg + 1'b1;
    end
  end

  assign perf_branches    = perf_branches_reg;
  assign perf_mispredicts = perf_mispredicts_reg;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the combinational branch decoder: decodes RV32 B-type branches, evaluates the condition, computes target/redirect PC, detects mispredicts.
- Owns a PC-indexed branch history table (BHT) of saturating counters serving fetch-stage prediction lookups.
- Sits between execute and fetch. Single-entry registered output stage with valid/ready handshake, plus saturating performance counters.

Parameters:
XLEN, 32, operand and PC width
BHT_ENTRIES, 64, number of BHT counters (power of two, >=2); IDX = log2(BHT_ENTRIES)
CNT_BITS, 2, width of each saturating counter (>=1); predict taken when MSB=1
PERF_BITS, 32, width of performance counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  squash output register and same-cycle input
in_valid  in  1  resolve request valid
in_ready  out  1  unit can accept request
op  in  7  instruction opcode
funct3  in  3  instruction funct3
branch  in  1  control-unit branch enable
pc  in  XLEN  branch instruction PC
imm  in  XLEN  sign-extended B-immediate
rs1_val  in  XLEN  operand 1
rs2_val  in  XLEN  operand 2
pred_taken  in  1  prediction fetch used for this instruction
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_is_branch  out  1  valid branch decoded
out_taken  out  1  resolved direction
out_mispredict  out  1  redirect required
out_redirect_pc  out  XLEN  correct next PC
out_illegal  out  1  opcode 1100011 with branch=1 and funct3 010/011
lookup_pc  in  XLEN  fetch PC for prediction
lookup_taken  out  1  combinational prediction, MSB of indexed counter
perf_branches  out  PERF_BITS  resolved-branch count
perf_mispredicts  out  PERF_BITS  mispredicted-branch count

Behaviour:
- Clock: single clock clk. Reset: synchronous, active-low (rst_n). Sampled only on the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - out_valid=0; all out_* data fields = 0.
  - Every BHT counter = 01 (generally 2^(CNT_BITS-1)-1, weakly not-taken).
  - perf_branches = perf_mispredicts = 0.
- Reset mid-operation discards the held result.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready && !flush.
  - On accept, the result is registered; out_valid=1 the next cycle. Latency is 1 cycle.
  - Full throughput when out_ready is held 1.
  - While out_valid && !out_ready, all out_* fields hold stable.
  - out_valid falls after out_ready with no new accept.
- Decode: is_branch = (op==1100011) && branch && funct3 in {000,001,100,101,110,111}.
- Condition: beq eq; bne ne; blt signed lt; bge signed ge; bltu unsigned lt; bgeu unsigned ge. Full XLEN compare.
- taken = is_branch && condition; illegal funct3 gives taken=0, out_illegal=1.
- redirect_pc:
  - taken: pc+imm, modulo 2^XLEN (wraps, no overflow flag).
  - otherwise: pc+4, also wrapping.
- mispredict = (taken != pred_taken). Non-branch or illegal with pred_taken=1 is a mispredict redirecting to pc+4.
- BHT:
  - index = pc[IDX+1:2].
  - On accept with is_branch=1: taken increments the counter, saturating at all-ones; not-taken decrements it, saturating at 0.
  - Non-branch and illegal requests do not update the BHT.
- Lookup: lookup_taken = MSB of counter[lookup_pc[IDX+1:2]], combinational.
  - Same-cycle update to the same index is NOT bypassed: lookup sees the old value, the new value is visible the next cycle.
- Perf counters: on accept with is_branch=1, perf_branches+1; if also mispredict, perf_mispredicts+1.
  - Both saturate at all-ones (no wrap).
- Flush (priority over everything except reset):
  - out_valid<=0.
  - A same-cycle input is not accepted: no BHT or perf update.
  - in_ready still follows its formula.
- Simultaneous out_ready and accept: the old result retires and the new one loads in the same edge; out_valid stays 1.

Test Plan:
- Reset, then lookup_pc=0x100 -> lookup_taken=0. perf counters 0, out_valid=0, in_ready=1.
- beq, pc=0x100, imm=0x20, rs1=rs2=5, pred_taken=0, out_ready=1 -> next cycle: out_taken=1, out_mispredict=1, out_redirect_pc=0x120, perf_branches=1, perf_mispredicts=1. Lookup 0x100 now returns 1 (counter 10).
- blt rs1=0xFFFFFFFF, rs2=1 -> taken. bltu same operands -> not taken, redirect pc+4. Two further taken branches at the same index -> counter saturates at 11; a fourth taken leaves it at 11.
- out_ready=0 with out_valid=1 -> in_ready=0, outputs stable for 5 cycles, new in_valid not accepted. Raising out_ready gives back-to-back accept, out_valid stays 1.
- funct3=010, op=1100011, branch=1, pred_taken=1 -> out_illegal=1, out_taken=0, mispredict=1, redirect pc+4, no BHT/perf change. pc=0xFFFFFFFC not taken -> redirect 0x0.
- flush asserted with in_valid=1 and a pending result -> out_valid=0 next cycle, BHT and perf unchanged. rst_n=0 mid-stream -> all outputs and counters reset on the next edge.
